mipi_interface: RTL and testbench
=================================

MIPI_INTERFACE -- requirements
Module: mipi_interface

Interface
REQ-001 CAM_CLK  input  1  sole clock; all state samples CAM_DATA_i and updates on its rising edge.
REQ-002 RESET  input  1  asynchronous, active-low reset; 0 forces the reset state immediately, released synchronously to CAM_CLK.
REQ-003 CAM_DATA_i  input  4  camera nibble stream, one nibble per CAM_CLK cycle.
REQ-004 VSYNC  output  1  frame-start indication.
REQ-005 HSYNC  output  1  line-start indication.
REQ-006 LINE_END  output  1  marks the last pixel word of a line.
REQ-007 PCLK  output  1  pixel strobe, derived from CAM_CLK; data valid on its rising edge.
REQ-008 DATA_OUT  output  16  current pixel word.
REQ-009 ADDRA  output  10  pixel index within the line, 0..959.
REQ-010 Parameter PIXELS_PER_LINE, default 960, number of 16-bit pixel words per data packet.

Function
REQ-011 Word assembly: four consecutive nibbles n0..n3 form word {n0,n1,n2,n3}; n0 is the MSB nibble.
REQ-012 HUNT state: a 48-bit nibble shift register shall be searched every cycle at any nibble offset for the sync pattern 0x0000_0000_0CFC (last nibble newest).
REQ-013 On sync match, the FSM enters TYPE and is word-aligned to the nibble immediately following the pattern.
REQ-014 TYPE decodes the next word: 0x0000 = frame start, 0xC000 = line start, 0xCCC0 = data packet, any other value returns to HUNT with no output effect.
REQ-015 Frame start: VSYNC high for exactly 4 CAM_CLK cycles, starting the cycle after the type word's last nibble is sampled; then HUNT.
REQ-016 Line start: HSYNC high for exactly 4 CAM_CLK cycles with the same timing as VSYNC; then HUNT.
REQ-017 Data packet: FSM enters HEADER, discards exactly one 4-nibble word (value ignored), then enters PAYLOAD.
REQ-018 PAYLOAD: assembles PIXELS_PER_LINE words; on the edge after each word's 4th nibble, DATA_OUT takes the word and ADDRA its index (first word 0).
REQ-019 PCLK stays low for the 2 cycles following each DATA_OUT update and is high for the next 2 cycles (period 4, data centred on the rising edge).
REQ-020 LINE_END is high for the 4 cycles during which the word with index PIXELS_PER_LINE-1 is presented; low otherwise.
REQ-021 After the last word's PCLK high phase, PCLK returns low and the FSM returns to HUNT; sync search is disabled throughout HEADER and PAYLOAD.
REQ-022 Outside PAYLOAD, DATA_OUT and ADDRA hold their last values; PCLK is 0.
REQ-023 VSYNC and HSYNC are never both high; a new sync match cannot occur while a 4-cycle VSYNC/HSYNC pulse is in progress, and the pulse always completes.
REQ-024 ADDRA never exceeds PIXELS_PER_LINE-1 and does not wrap within a packet.

Reset
REQ-025 While RESET=0: FSM=HUNT, shift register cleared to 0xF…F (so it cannot false-match zeros), VSYNC=HSYNC=LINE_END=PCLK=0, DATA_OUT=0, ADDRA=0.
REQ-026 Reset asserted mid-packet aborts the packet at once; after release, operation resumes only on a fresh sync pattern.

Verification
REQ-027 Sync 0x0000_0000_0CFC followed by type 0x0000 -> VSYNC high 4 cycles, HSYNC/PCLK stay 0.
REQ-028 Single nibble 0x5, then sync with type 0xC000 (misaligned by one nibble) -> HSYNC high 4 cycles.
REQ-029 Sync, type 0xCCC0, header 0xFFFF, 3840 nibbles i mod 16 -> DATA_OUT cycles 0x0123,0x4567,0x89AB,0xCDEF; ADDRA 0..959; 960 PCLK rising edges.
REQ-030 Same packet -> LINE_END high only while ADDRA=959; then a second VSYNC/HSYNC/data sequence immediately following decodes identically.
REQ-031 Type word 0x1234 after sync -> no output pulses, FSM back in HUNT, next valid sync recognised.
REQ-032 RESET driven low at ADDRA=500 -> all outputs 0 immediately; nibbles after release ignored until a new sync.

Source files
------------

// File: rtl/mipi_interface.sv
// mipi_interface: recovers frame/line sync markers and pixel payloads from a
// nibble-serial camera stream. A 48-bit history of nibbles is searched for the
// sync pattern. The type word that follows the pattern selects one of three
// actions: a 4-cycle VSYNC pulse, a 4-cycle HSYNC pulse, or a data packet.
// A data packet is presented as 16-bit words with a slow PCLK strobe.
//
// Handshake: there is no back-pressure. Each word is valid on DATA_OUT/ADDRA
// from the cycle it updates until the next update. PCLK rises mid-word, so a
// consumer samples DATA_OUT/ADDRA/LINE_END on the PCLK rising edge.
module mipi_interface #(
  parameter int PIXELS_PER_LINE = 960
) (
  input  logic        CAM_CLK,
  input  logic        RESET,
  input  logic [3:0]  CAM_DATA_i,
  output logic        VSYNC,
  output logic        HSYNC,
  output logic        LINE_END,
  output logic        PCLK,
  output logic [15:0] DATA_OUT,
  output logic [9:0]  ADDRA,
  output logic [2:0]  dbg_state
);

  localparam logic [47:0] SYNC_PAT = 48'h0000_0000_0CFC;
  localparam int CW = $clog2(PIXELS_PER_LINE + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(PIXELS_PER_LINE);
  localparam logic [CW-1:0] LAST_IDX = CW'(PIXELS_PER_LINE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_TYPE    = 3'd1,
    ST_PULSE   = 3'd2,
    ST_HEADER  = 3'd3,
    ST_PAYLOAD = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [47:0]   sr_q, sr_d;
  logic [11:0]   word_q, word_d;
  logic [1:0]    nib_cnt_q, nib_cnt_d;
  logic [CW-1:0] pix_cnt_q, pix_cnt_d;
  logic          vsync_q, vsync_d;
  logic          hsync_q, hsync_d;
  logic          line_end_q, line_end_d;
  logic          pclk_q, pclk_d;
  logic [15:0]   data_q, data_d;
  logic [9:0]    addra_q, addra_d;
  logic [15:0]   full_word;

  // The current nibble completes a 16-bit word whose first three nibbles are
  // already held in word_q.
  assign full_word = {word_q, CAM_DATA_i};

  // Next-state logic for the sync hunter, the type decoder and the payload
  // word assembler.
  always_comb begin
    state_d    = state_q;
    sr_d       = {sr_q[43:0], CAM_DATA_i};
    word_d     = {word_q[7:0], CAM_DATA_i};
    nib_cnt_d  = nib_cnt_q + 2'd1;
    pix_cnt_d  = pix_cnt_q;
    vsync_d    = vsync_q;
    hsync_d    = hsync_q;
    line_end_d = line_end_q;
    pclk_d     = 1'b0;
    data_d     = data_q;
    addra_d    = addra_q;

    case (state_q)
      ST_HUNT: begin
        // sr_q holds the 12 newest nibbles. On a hit, the current nibble is
        // already the first type nibble, so counting starts at 1.
        if (sr_q == SYNC_PAT) begin
          state_d   = ST_TYPE;
          nib_cnt_d = 2'd1;
        end else begin
          nib_cnt_d = 2'd0;
        end
      end

      ST_TYPE: begin
        if (nib_cnt_q == 2'd3) begin
          case (full_word)
            16'h0000: begin
              vsync_d = 1'b1;
              state_d = ST_PULSE;
            end
            16'hC000: begin
              hsync_d = 1'b1;
              state_d = ST_PULSE;
            end
            16'hCCC0: state_d = ST_HEADER;
            default:  state_d = ST_HUNT;
          endcase
        end
      end

      ST_PULSE: begin
        // The pulse was raised on entry. Four cycles later it drops and the
        // search resumes. No matching is done while the pulse is running.
        if (nib_cnt_q == 2'd3) begin
          vsync_d = 1'b0;
          hsync_d = 1'b0;
          state_d = ST_HUNT;
        end
      end

      ST_HEADER: begin
        if (nib_cnt_q == 2'd3) begin
          state_d   = ST_PAYLOAD;
          pix_cnt_d = '0;
        end
      end

      ST_PAYLOAD: begin
        // PCLK is high on the 3rd and 4th cycles after each word update.
        // pix_cnt_q counts the words already presented.
        pclk_d = (pix_cnt_q != '0) && ((nib_cnt_q == 2'd1) || (nib_cnt_q == 2'd2));
        if (nib_cnt_q == 2'd3) begin
          if (pix_cnt_q == LAST_CNT) begin
            // The last word's strobe is complete. This nibble belongs to
            // whatever follows the packet.
            line_end_d = 1'b0;
            state_d    = ST_HUNT;
          end else begin
            data_d     = full_word;
            addra_d    = 10'(pix_cnt_q);
            pix_cnt_d  = pix_cnt_q + CNT_ONE;
            line_end_d = (pix_cnt_q == LAST_IDX);
          end
        end
      end

      default: state_d = ST_HUNT;
    endcase
  end

  // State and registered outputs. Reset fills the history with ones so that
  // a run of zero nibbles after reset cannot form a false match.
  always_ff @(posedge CAM_CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_HUNT;
      sr_q       <= '1;
      word_q     <= '0;
      nib_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      vsync_q    <= 1'b0;
      hsync_q    <= 1'b0;
      line_end_q <= 1'b0;
      pclk_q     <= 1'b0;
      data_q     <= '0;
      addra_q    <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      word_q     <= word_d;
      nib_cnt_q  <= nib_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      vsync_q    <= vsync_d;
      hsync_q    <= hsync_d;
      line_end_q <= line_end_d;
      pclk_q     <= pclk_d;
      data_q     <= data_d;
      addra_q    <= addra_d;
    end
  end

  assign VSYNC     = vsync_q;
  assign HSYNC     = hsync_q;
  assign LINE_END  = line_end_q;
  assign PCLK      = pclk_q;
  assign DATA_OUT  = data_q;
  assign ADDRA     = addra_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mipi_interface.sv
// tb_mipi_interface: drives nibble streams into mipi_interface.
// Each row of a type-word table is compared by counting VSYNC/HSYNC pulses.
// Payload words are compared by a scoreboard queue that is filled as the
// stimulus is driven and drained on each PCLK rising edge.
module tb_mipi_interface;

  logic        CAM_CLK = 1'b0;
  logic        RESET;
  logic [3:0]  CAM_DATA_i;
  logic        VSYNC, HSYNC, LINE_END, PCLK;
  logic [15:0] DATA_OUT;
  logic [9:0]  ADDRA;
  logic [2:0]  dbg_state;

  localparam int NPIX = 960;

  mipi_interface #(.PIXELS_PER_LINE(NPIX)) dut (
    .CAM_CLK    (CAM_CLK),
    .RESET      (RESET),
    .CAM_DATA_i (CAM_DATA_i),
    .VSYNC      (VSYNC),
    .HSYNC      (HSYNC),
    .LINE_END   (LINE_END),
    .PCLK       (PCLK),
    .DATA_OUT   (DATA_OUT),
    .ADDRA      (ADDRA),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CAM_CLK = ~CAM_CLK;

  int checks = 0;
  int errors = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [26:0] exp_q[$];
  int v_pulses = 0, h_pulses = 0, pclk_rises = 0;
  int v_run = 0, h_run = 0, p_run = 0, le_run = 0;
  logic pclk_prev = 1'b0;

  always @(negedge CAM_CLK) begin
    logic [26:0] e;
    if (RESET) begin
      check("sync_exclusive", {31'd0, VSYNC & HSYNC}, 32'd0);
      if (VSYNC) v_run++;
      else if (v_run != 0) begin
        check("vsync_len", v_run, 4);
        v_pulses++;
        v_run = 0;
      end
      if (HSYNC) h_run++;
      else if (h_run != 0) begin
        check("hsync_len", h_run, 4);
        h_pulses++;
        h_run = 0;
      end
      if (LINE_END) begin
        check("line_end_addr", {22'd0, ADDRA}, NPIX - 1);
        le_run++;
      end else if (le_run != 0) begin
        check("line_end_len", le_run, 4);
        le_run = 0;
      end
      if (PCLK) begin
        if (!pclk_prev) begin
          pclk_rises++;
          if (exp_q.size() == 0) check("pclk_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            check("pix_word", {5'd0, LINE_END, ADDRA, DATA_OUT}, {5'd0, e});
          end
        end
        p_run++;
      end else if (p_run != 0) begin
        check("pclk_high_len", p_run, 2);
        p_run = 0;
      end
    end else begin
      v_run = 0; h_run = 0; p_run = 0; le_run = 0;
    end
    pclk_prev = PCLK;
  end

  // ---------------- driver tasks ----------------
  task automatic send_nib(input logic [3:0] n);
    @(negedge CAM_CLK);
    CAM_DATA_i = n;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int j = 0; j < 4; j++) send_nib(w[15-4*j -: 4]);
  endtask

  task automatic send_sync();
    send_word(16'h0000);
    send_word(16'h0000);
    send_word(16'h0CFC);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_nib(4'hF);
  endtask

  // Sync, data type, header, then n_words payload words built from i mod 16.
  task automatic send_packet(input int n_words);
    logic [15:0] w;
    send_sync();
    send_word(16'hCCC0);
    send_word(16'hFFFF);
    for (int k = 0; k < n_words; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        w = {w[11:0], 4'((4 * k + j) % 16)};
        send_nib(4'((4 * k + j) % 16));
      end
      exp_q.push_back({(k == NPIX - 1), 10'(k), w});
    end
  endtask

  // ---------------- type-word table ----------------
  typedef struct {
    logic        pre;
    logic [15:0] type_w;
    int          exp_v;
    int          exp_h;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0, h0, p0;
    vecs[0] = '{pre: 1'b0, type_w: 16'h0000, exp_v: 1, exp_h: 0};
    vecs[1] = '{pre: 1'b1, type_w: 16'hC000, exp_v: 0, exp_h: 1};
    vecs[2] = '{pre: 1'b0, type_w: 16'h1234, exp_v: 0, exp_h: 0};
    vecs[3] = '{pre: 1'b0, type_w: 16'hC000, exp_v: 0, exp_h: 1};
    vecs[4] = '{pre: 1'b0, type_w: 16'hFFFF, exp_v: 0, exp_h: 0};
    vecs[5] = '{pre: 1'b1, type_w: 16'h0000, exp_v: 1, exp_h: 0};

    // reset state
    RESET = 1'b0;
    CAM_DATA_i = 4'hF;
    repeat (3) @(negedge CAM_CLK);
    #1;
    check("rst_vsync", {31'd0, VSYNC}, 32'd0);
    check("rst_hsync", {31'd0, HSYNC}, 32'd0);
    check("rst_line_end", {31'd0, LINE_END}, 32'd0);
    check("rst_pclk", {31'd0, PCLK}, 32'd0);
    check("rst_data", {16'd0, DATA_OUT}, 32'd0);
    check("rst_addra", {22'd0, ADDRA}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    @(negedge CAM_CLK);
    RESET = 1'b1;
    idle(4);

    // table of type words
    for (int r = 0; r < 6; r++) begin
      v0 = v_pulses; h0 = h_pulses; p0 = pclk_rises;
      if (vecs[r].pre) send_nib(4'h5);
      send_sync();
      send_word(vecs[r].type_w);
      idle(8);
      check("row_vsync", v_pulses - v0, vecs[r].exp_v);
      check("row_hsync", h_pulses - h0, vecs[r].exp_h);
      check("row_pclk", pclk_rises - p0, 0);
      check("row_state", {29'd0, dbg_state}, 32'd0);
    end

    // one full packet followed back-to-back by frame start, line start, packet
    v0 = v_pulses; h0 = h_pulses; p0 = pclk_rises;
    send_packet(NPIX);
    send_sync();
    send_word(16'h0000);
    send_sync();
    send_word(16'hC000);
    send_packet(NPIX);
    idle(8);
    check("b2b_pclk_count", pclk_rises - p0, 2 * NPIX);
    check("b2b_vsync", v_pulses - v0, 1);
    check("b2b_hsync", h_pulses - h0, 1);
    check("b2b_sb_empty", exp_q.size(), 0);
    check("hold_data", {16'd0, DATA_OUT}, 32'h0000_CDEF);
    check("hold_addra", {22'd0, ADDRA}, NPIX - 1);
    check("hold_line_end", {31'd0, LINE_END}, 32'd0);
    check("hold_pclk", {31'd0, PCLK}, 32'd0);
    check("hold_state", {29'd0, dbg_state}, 32'd0);

    // reset mid-packet while word 500 is presented
    v0 = v_pulses; h0 = h_pulses; p0 = pclk_rises;
    send_packet(501);
    for (int j = 0; j < 3; j++) send_nib(4'((4 * 501 + j) % 16));
    @(posedge CAM_CLK);
    #2;
    check("mid_addra", {22'd0, ADDRA}, 32'd500);
    check("mid_pclk", {31'd0, PCLK}, 32'd1);
    check("mid_sb_empty", exp_q.size(), 0);
    RESET = 1'b0;
    #1;
    check("abort_pclk", {31'd0, PCLK}, 32'd0);
    check("abort_data", {16'd0, DATA_OUT}, 32'd0);
    check("abort_addra", {22'd0, ADDRA}, 32'd0);
    check("abort_line_end", {31'd0, LINE_END}, 32'd0);
    check("abort_state", {29'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge CAM_CLK);
    RESET = 1'b1;
    for (int i = 4 * 501 + 3; i < 4 * 560; i++) send_nib(4'(i % 16));
    idle(8);
    check("post_rst_pclk", pclk_rises - p0, 501);
    check("post_rst_vsync", v_pulses - v0, 0);
    check("post_rst_hsync", h_pulses - h0, 0);
    check("post_rst_state", {29'd0, dbg_state}, 32'd0);
    send_sync();
    send_word(16'hC000);
    idle(8);
    check("post_rst_resync", h_pulses - h0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
